regfile_mp: RTL
===============

# regfile_mp

Parametrised multi-port register file for the single-cycle datapath, next generation of the 32×32 two-read/one-write file. It adds configurable width, depth and read-port count, a second write port, hardwired zero register, optional same-cycle write-to-read bypass, synchronous clear and a per-register busy scoreboard. The scoreboard tracks registers with an outstanding multi-cycle producer, such as a memory load. It sits between decode (read addresses, busy marking) and writeback (two result buses).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, is never busy
- BYPASS, 1, 1 = a read of an address being written this cycle returns the new data

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, packed the same way
- rd_busy  out  NUM_RD  busy flag of each read address
- we0, wa0, wd0  in  1 / ADDR_W / DATA_W  write port 0 (ALU result)
- we1, wa1, wd1  in  1 / ADDR_W / DATA_W  write port 1 (memory result)
- busy_set  in  1  mark busy_addr pending at this edge
- busy_addr  in  ADDR_W  register to mark pending
- any_busy  out  1  OR of all busy bits (registered state)

## Operation
- Storage: 2**ADDR_W × DATA_W array plus a 2**ADDR_W-bit busy vector.
- Reset: on a clk edge with rst=1, every register is cleared to 0 and every busy bit to 0. All write and busy_set inputs are ignored that edge.
- Writes: at each edge, weN=1 stores wdN into waN.
  - Both ports enabled with the same address: port 1 wins.
  - Different addresses: both are stored.
- Writes to address 0 are discarded when ZERO_REG=1.
- Busy clear: any enabled write to an address clears that address's busy bit at the same edge.
- Busy set: busy_set=1 sets busy[busy_addr].
  - busy_set together with a write to the same address: set wins, and the bit is 1 after the edge.
  - busy_set to address 0 is ignored when ZERO_REG=1.
- Reads are combinational per port:
  - ZERO_REG=1 and address 0: data is 0 and busy is 0.
  - Else, if BYPASS=1 and we1 matches the address (nonzero or ZERO_REG=0): data = wd1, busy = 0.
  - Else, if BYPASS=1 and we0 matches: data = wd0, busy = 0.
  - Else: data = array[addr], busy = busy[addr].
- Bypass is not applied while rst=1. Reads then return stored contents.
- No read-port conflicts. All NUM_RD ports may use the same address.

## Timing
- Write latency:
  - BYPASS=1: written data is visible on a read the same cycle (combinational) and from the array on the next cycle.
  - BYPASS=0: visible only after the edge.
- busy_set: the flag appears on rd_busy and any_busy the cycle after the edge.
- Busy clear by write:
  - BYPASS=1: rd_busy drops combinationally in the write cycle.
  - any_busy is registered state only and drops after the edge.
- Reset output values: rd_data = 0 for every address, rd_busy = 0, any_busy = 0 from the first cycle after the reset edge.
- Reset mid-operation: pending busy bits and stored data are lost. Writes coinciding with the reset edge are dropped.
- Single clock domain. No combinational path from the busy_set inputs to any output.

## Test plan
- Reset then read all addresses: rst high for 1 edge, sweep rd_addr 0..31 -> rd_data = 0, rd_busy = 0, any_busy = 0.
- Same-address dual write: we0 = we1 = 1, wa0 = wa1 = 5, wd0 = 0x1111_1111, wd1 = 0x2222_2222; next cycle read 5 -> 0x2222_2222.
- Bypass: we0 = 1, wa0 = 7, wd0 = 0xDEAD_BEEF with rd_addr port 0 = 7 in the same cycle -> rd_data = 0xDEAD_BEEF (BYPASS=1). With BYPASS=0 the read shows the old value, 0.
- Zero register: write 0xFFFF_FFFF to address 0 and busy_set on 0 -> read 0 gives data 0, busy 0, any_busy 0.
- Scoreboard:
  - busy_set on 9 -> next cycle rd_busy = 1, any_busy = 1.
  - we1 to 9 with 0x0000_00AB -> same cycle rd_busy = 0 (bypass); next cycle any_busy = 0 and read gives 0x0000_00AB.
  - busy_set and write to 9 in the same cycle -> busy stays 1.
- Parameter variant DATA_W=16, ADDR_W=3, NUM_RD=4: write 0x1234 to 3, all four ports read 3 -> each returns 0x1234.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file with two write ports, an optional zero register,
// same-cycle write-to-read bypass and a per-register busy scoreboard.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd1,
  input  logic                     busy_set,
  input  logic [ADDR_W-1:0]        busy_addr,
  output logic                     any_busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);
  localparam bit BP    = (BYPASS != 0);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;

  logic wr0_en;
  logic wr1_en;
  logic set_en;

  // Register 0 is invisible to writes and busy marking when hardwired to zero.
  assign wr0_en = we0 && !(ZR && (wa0 == '0));
  assign wr1_en = we1 && !(ZR && (wa1 == '0));
  assign set_en = busy_set && !(ZR && (busy_addr == '0));

  always_comb begin
    busy_d = busy_q;
    if (wr0_en) busy_d[wa0] = 1'b0;
    if (wr1_en) busy_d[wa1] = 1'b0;
    if (set_en) busy_d[busy_addr] = 1'b1;
    if (rst) busy_d = '0;
  end

  always_ff @(posedge clk) begin
    busy_q <= busy_d;
  end

  // Port 1 has priority, so port 0 is suppressed on an address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (wr0_en && !(wr1_en && (wa1 == wa0))) mem_q[wa0] <= wd0;
      if (wr1_en) mem_q[wa1] <= wd1;
    end
  end

  assign any_busy = |busy_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              is_zero;
    logic              hit0;
    logic              hit1;
    logic [DATA_W-1:0] data;
    logic              busy;

    assign addr    = rd_addr[k*ADDR_W +: ADDR_W];
    assign is_zero = ZR && (addr == '0);
    assign hit1    = BP && !rst && wr1_en && (wa1 == addr);
    assign hit0    = BP && !rst && wr0_en && (wa0 == addr);

    always_comb begin
      data = mem_q[addr];
      busy = busy_q[addr];
      if (is_zero) begin
        data = '0;
        busy = 1'b0;
      end else if (hit1) begin
        data = wd1;
        busy = 1'b0;
      end else if (hit0) begin
        data = wd0;
        busy = 1'b0;
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = data;
    assign rd_busy[k]                  = busy;
  end

endmodule
